// File: rtl/aes_encipher_sequencer.sv
// Iterative AES encipher sequencer: owns the 128-bit state and round counter, walks the key
// memory by round index and time-shares a 4-byte S-box bank one state word per cycle.
module aes_encipher_sequencer #(
    parameter int AES128_ROUNDS = 10,
    parameter int AES256_ROUNDS = 14
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_next,
    input  logic         i_keylen,
    input  logic [127:0] i_block,
    output logic [3:0]   o_round_key_addr,
    input  logic [127:0] i_round_key,
    output logic [31:0]  o_sboxw,
    input  logic [31:0]  i_new_sboxw,
    output logic [127:0] o_new_block,
    output logic         o_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SUB,
        S_RND,
        S_FIN
    } fsm_t;

    localparam logic [3:0] NR128 = 4'(AES128_ROUNDS);
    localparam logic [3:0] NR256 = 4'(AES256_ROUNDS);

    fsm_t         r_fsm, w_fsm_next;
    logic [127:0] r_state, w_state_next;
    logic [3:0]   r_round_ctr, w_round_ctr_next;
    logic [1:0]   r_word_ctr, w_word_ctr_next;
    logic         r_keylen, w_keylen_next;
    logic         r_ready, w_ready_next;
    logic [3:0]   w_nr;
    logic [31:0]  w_cur_word;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // One column through the {02 03 01 01} circulant; byte 0 (row 0) is the MSB.
    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    assign w_nr = r_keylen ? NR256 : NR128;

    always_comb begin
        w_cur_word = r_state[127:96];
        case (r_word_ctr)
            2'd0: w_cur_word = r_state[127:96];
            2'd1: w_cur_word = r_state[95:64];
            2'd2: w_cur_word = r_state[63:32];
            2'd3: w_cur_word = r_state[31:0];
            default: w_cur_word = r_state[127:96];
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_fsm_next       = r_fsm;
        w_state_next     = r_state;
        w_round_ctr_next = r_round_ctr;
        w_word_ctr_next  = r_word_ctr;
        w_keylen_next    = r_keylen;
        w_ready_next     = r_ready;
        o_round_key_addr = 4'd0;
        o_sboxw          = 32'h0;

        unique case (r_fsm)
            S_IDLE: begin
                if (i_next) begin
                    w_state_next     = i_block;
                    w_keylen_next    = i_keylen;
                    w_ready_next     = 1'b0;
                    w_round_ctr_next = 4'd0;
                    w_fsm_next       = S_INIT;
                end
            end
            S_INIT: begin
                w_state_next     = r_state ^ i_round_key;
                w_round_ctr_next = 4'd1;
                w_word_ctr_next  = 2'd0;
                w_fsm_next       = S_SUB;
            end
            S_SUB: begin
                o_round_key_addr = r_round_ctr;
                o_sboxw          = w_cur_word;
                case (r_word_ctr)
                    2'd0: w_state_next[127:96] = i_new_sboxw;
                    2'd1: w_state_next[95:64]  = i_new_sboxw;
                    2'd2: w_state_next[63:32]  = i_new_sboxw;
                    2'd3: w_state_next[31:0]   = i_new_sboxw;
                    default: w_state_next = r_state;
                endcase
                w_word_ctr_next = r_word_ctr + 2'd1;
                if (r_word_ctr == 2'd3) begin
                    w_fsm_next = (r_round_ctr < w_nr) ? S_RND : S_FIN;
                end
            end
            S_RND: begin
                o_round_key_addr = r_round_ctr;
                w_state_next     = mix_columns(shift_rows(r_state)) ^ i_round_key;
                w_round_ctr_next = r_round_ctr + 4'd1;
                w_fsm_next       = S_SUB;
            end
            S_FIN: begin
                o_round_key_addr = w_nr;
                w_state_next     = shift_rows(r_state) ^ i_round_key;
                w_ready_next     = 1'b1;
                w_fsm_next       = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_round_ctr <= 4'd0;
            r_word_ctr  <= 2'd0;
            r_keylen    <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_fsm       <= w_fsm_next;
            r_state     <= w_state_next;
            r_round_ctr <= w_round_ctr_next;
            r_word_ctr  <= w_word_ctr_next;
            r_keylen    <= w_keylen_next;
            r_ready     <= w_ready_next;
        end
    end

    assign o_new_block = r_state;
    assign o_ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_sequencer.sv
// Self-checking bench: models the key memory and S-box bank, runs FIPS-197 vectors and
// multi-cycle corner cases (busy re-pulse, mid-operation reset, back-to-back starts).
module tb_aes_encipher_sequencer;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_next;
    logic         i_keylen;
    logic [127:0] i_block;
    logic [3:0]   o_round_key_addr;
    logic [127:0] i_round_key;
    logic [31:0]  o_sboxw;
    logic [31:0]  i_new_sboxw;
    logic [127:0] o_new_block;
    logic         o_ready;

    int n_checks;
    int n_fail;

    logic [127:0] rk [0:15];

    typedef struct {
        bit           kl;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [0:4];

    aes_encipher_sequencer dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_next           (i_next),
        .i_keylen         (i_keylen),
        .i_block          (i_block),
        .o_round_key_addr (o_round_key_addr),
        .i_round_key      (i_round_key),
        .o_sboxw          (o_sboxw),
        .i_new_sboxw      (i_new_sboxw),
        .o_new_block      (o_new_block),
        .o_ready          (o_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: GF(2^8) inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = b;
        for (int i = 1; i < 8; i++) begin
            sq = gm(sq, sq);
            r  = gm(r, sq);
        end
        if (b == 8'h00) r = 8'h00;
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign i_round_key = rk[o_round_key_addr];
    assign i_new_sboxw = sub_word(o_sboxw);

    // Key schedule into the modelled key memory; AES-128 keys sit in the upper half of key.
    task automatic load_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr, total;
        nk    = kl ? 8 : 4;
        nr    = kl ? 14 : 10;
        total = 4 * (nr + 1);
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k < 16; k++) begin
            rk[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
        end
    endtask

    task automatic check(input string what, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    // Load vector v and pulse next; returns at the negedge after the accepting edge.
    task automatic start(input int v);
        load_key(vecs[v].key, vecs[v].kl);
        i_block  = vecs[v].pt;
        i_keylen = vecs[v].kl;
        i_next   = 1'b1;
        @(negedge clk);
        i_next   = 1'b0;
        i_block  = ~vecs[v].pt;
        i_keylen = ~vecs[v].kl;
        check($sformatf("v%0d busy after accept", v), {127'h0, o_ready}, 128'h0);
        check($sformatf("v%0d state loaded", v), o_new_block, vecs[v].pt);
    endtask

    // Counts edges from the accepting edge (inclusive) until ready returns, tracking the
    // distinct round-key addresses in order; optionally re-pulses next or stops early.
    task automatic track(input int nr, input int stop_at, input int pulse_at,
                         input logic [127:0] pulse_blk, output int edges, output bit addr_ok);
        int expect_addr;
        int last;
        edges       = 1;
        expect_addr = 0;
        last        = -1;
        addr_ok     = 1'b1;
        while (o_ready == 1'b0 && edges < 200 && edges != stop_at) begin
            if (int'(o_round_key_addr) != last) begin
                if (int'(o_round_key_addr) != expect_addr) addr_ok = 1'b0;
                last = int'(o_round_key_addr);
                expect_addr++;
            end
            if (edges == pulse_at) begin
                i_next  = 1'b1;
                i_block = pulse_blk;
            end else if (edges == pulse_at + 1) begin
                i_next = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        if (stop_at < 0 && expect_addr != nr + 1) addr_ok = 1'b0;
    endtask

    task automatic finish_vec(input int v, input int edges, input bit addr_ok);
        check($sformatf("v%0d latency edges", v), 128'(edges), vecs[v].kl ? 128'd72 : 128'd52);
        check($sformatf("v%0d key addr order", v), {127'h0, addr_ok}, 128'h1);
        check($sformatf("v%0d ready", v), {127'h0, o_ready}, 128'h1);
        check($sformatf("v%0d ciphertext", v), o_new_block, vecs[v].ct);
        check($sformatf("v%0d idle sboxw", v), {96'h0, o_sboxw}, 128'h0);
    endtask

    task automatic run_vec(input int v);
        int  edges;
        bit  ok;
        start(v);
        track(vecs[v].kl ? 14 : 10, -1, -1, 128'h0, edges, ok);
        finish_vec(v, edges, ok);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  edges;
        bit  ok;
        n_checks = 0;
        n_fail   = 0;
        i_reset  = 1'b1;
        i_next   = 1'b0;
        i_keylen = 1'b0;
        i_block  = 128'h0;

        vecs[0] = '{kl: 1'b0, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{kl: 1'b0, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    pt: 128'h3243f6a8885a308d313198a2e0370734,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{kl: 1'b1, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{kl: 1'b0, key: 256'h0, pt: 128'h0,
                    ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[4] = '{kl: 1'b1, key: 256'h0, pt: 128'h0,
                    ct: 128'hdc95c078a2408989ad48a21492842087};

        load_key(vecs[0].key, 1'b0);
        repeat (3) @(negedge clk);
        check("reset ready", {127'h0, o_ready}, 128'h1);
        check("reset new_block", o_new_block, 128'h0);
        check("reset sboxw", {96'h0, o_sboxw}, 128'h0);
        check("reset key addr", {124'h0, o_round_key_addr}, 128'h0);

        i_reset = 1'b0;
        i_block = 128'hdeadbeef;
        repeat (2) @(negedge clk);
        check("idle hold ready", {127'h0, o_ready}, 128'h1);
        check("idle hold state", o_new_block, 128'h0);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Busy guard: a second next with a different block mid-run must be ignored.
        start(0);
        track(10, -1, 20, vecs[1].pt, edges, ok);
        finish_vec(0, edges, ok);

        // Reset mid-operation, then a clean run.
        start(0);
        track(10, 30, -1, 128'h0, edges, ok);
        i_reset = 1'b1;
        @(negedge clk);
        check("midreset ready", {127'h0, o_ready}, 128'h1);
        check("midreset new_block", o_new_block, 128'h0);
        check("midreset sboxw", {96'h0, o_sboxw}, 128'h0);
        i_reset = 1'b0;
        @(negedge clk);
        run_vec(0);

        // Back-to-back: next held high across two encryptions.
        load_key(vecs[0].key, 1'b0);
        i_block  = vecs[0].pt;
        i_keylen = 1'b0;
        i_next   = 1'b1;
        @(negedge clk);
        check("b2b first busy", {127'h0, o_ready}, 128'h0);
        track(10, -1, -1, 128'h0, edges, ok);
        finish_vec(0, edges, ok);
        load_key(vecs[2].key, 1'b1);
        i_block  = vecs[2].pt;
        i_keylen = 1'b1;
        @(negedge clk);
        check("b2b result one cycle", {127'h0, o_ready}, 128'h0);
        check("b2b second loaded", o_new_block, vecs[2].pt);
        i_block = 128'h0;
        track(14, -1, -1, 128'h0, edges, ok);
        i_next = 1'b0;
        finish_vec(2, edges, ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
